// File: rtl/seg_scan_driver.sv
// Six-digit common-cathode 7-segment scanner: per-frame digit snapshot,
// dead-time guard at the start of each slot, and blink of the digit under edit.
module seg_scan_driver #(
  parameter int SCAN_DIV     = 1000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] digit4,
  input  logic [3:0] digit5,
  input  logic       blink_en,
  input  logic [2:0] blink_pos,
  output logic [6:0] seg,
  output logic [5:0] sel
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DW-1:0]   div_cnt;
  logic [2:0]      idx;
  logic [FW-1:0]   frame_cnt;
  logic            blink_phase;
  logic [5:0][3:0] snap;
  logic [5:0][3:0] digits;
  logic [5:0][3:0] snap_eff;
  logic            div_last, frame_start, frame_end;
  logic [3:0]      cur;
  logic            blank;
  logic [6:0]      seg_nxt;
  logic [5:0]      sel_nxt;

  assign digits      = {digit5, digit4, digit3, digit2, digit1, digit0};
  assign div_last    = (div_cnt == DW'(SCAN_DIV - 1));
  assign frame_start = (idx == 3'd0) && (div_cnt == '0);
  assign frame_end   = (idx == 3'd5) && div_last;
  // At frame start the snapshot is being loaded this edge; show the fresh value.
  assign snap_eff    = frame_start ? digits : snap;
  assign cur         = snap_eff[idx];
  assign blank       = blink_en && blink_phase && (blink_pos == idx);

  always_comb begin
    seg_nxt = 7'b0000000;
    sel_nxt = 6'b111111;
    if (int'(div_cnt) >= GUARD) begin
      sel_nxt[idx] = 1'b0;
      if (!blank) begin
        case (cur)
          4'd0:    seg_nxt = 7'b0111111;
          4'd1:    seg_nxt = 7'b0000110;
          4'd2:    seg_nxt = 7'b1011011;
          4'd3:    seg_nxt = 7'b1001111;
          4'd4:    seg_nxt = 7'b1100110;
          4'd5:    seg_nxt = 7'b1101101;
          4'd6:    seg_nxt = 7'b1111101;
          4'd7:    seg_nxt = 7'b0000111;
          4'd8:    seg_nxt = 7'b1111111;
          4'd9:    seg_nxt = 7'b1101111;
          default: seg_nxt = 7'b0000000;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= 3'd0;
      snap    <= '0;
    end else begin
      if (frame_start) snap <= digits;
      if (div_last) begin
        div_cnt <= '0;
        idx     <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  // Blink counters are held idle while edit mode is off so re-entry starts lit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!blink_en) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 7'b0000000;
      sel <= 6'b111111;
    end else begin
      seg <= seg_nxt;
      sel <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a time-indexed model predicts every
// output cycle; each scenario task pops and compares at the falling edge.
module tb_seg_scan_driver;
  localparam int SD = 4, G = 1, BF = 2;
  localparam int FR = 6 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dig [6];
  logic       blink_en = 1'b0;
  logic [2:0] blink_pos = 3'd0;
  logic [6:0] seg;
  logic [5:0] sel;

  typedef struct packed { logic [5:0] sel; logic [6:0] seg; } exp_t;
  exp_t q[$];
  exp_t e, pe;
  int checks = 0, failures = 0;

  int pos = 0, wraps = 0, m_div, m_slot;
  logic [3:0] msnap [6];
  logic [3:0] mv;
  logic m_fs, m_phase;

  seg_scan_driver #(.SCAN_DIV(SD), .GUARD(G), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n),
    .digit0(dig[0]), .digit1(dig[1]), .digit2(dig[2]),
    .digit3(dig[3]), .digit4(dig[4]), .digit5(dig[5]),
    .blink_en(blink_en), .blink_pos(blink_pos), .seg(seg), .sel(sel));

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0111111;  4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;  4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;  4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;  4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;  4'd9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // pos = cycles since reset release; output after each edge reflects pos before it.
  always @(posedge clk) begin
    if (!rst_n) begin
      pos = 0; wraps = 0;
      for (int i = 0; i < 6; i++) msnap[i] = 4'd0;
      q.delete();
    end else begin
      m_div   = pos % SD;
      m_slot  = (pos / SD) % 6;
      m_fs    = (pos % FR) == 0;
      m_phase = ((wraps / BF) % 2) == 1;
      mv      = m_fs ? dig[m_slot] : msnap[m_slot];
      pe.sel  = 6'b111111;
      pe.seg  = 7'b0000000;
      if (m_div >= G) begin
        pe.sel[m_slot] = 1'b0;
        if (!(blink_en && m_phase && int'(blink_pos) == m_slot)) pe.seg = dec(mv);
      end
      q.push_back(pe);
      if (m_fs) for (int i = 0; i < 6; i++) msnap[i] = dig[i];
      if (!blink_en) wraps = 0;
      else if ((pos % FR) == FR - 1) wraps++;
      pos++;
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 6; i++) dig[i] = 4'(i);
    repeat (2) @(negedge clk);
    checks++;
    if (sel !== 6'b111111) begin failures++; $display("FAIL reset_sel got=%b exp=111111", sel); end
    checks++;
    if (seg !== 7'b0000000) begin failures++; $display("FAIL reset_seg got=%b exp=0000000", seg); end
    rst_n = 1'b1;
    for (int c = 0; c < 2 * FR; c++) begin
      @(negedge clk);
      checks++;
      if (q.size() == 0) begin failures++; $display("FAIL scan_basic no expected entry"); end
      else begin
        e = q.pop_front();
        if (sel !== e.sel || seg !== e.seg) begin
          failures++;
          $display("FAIL scan_basic t=%0t sel=%b exp=%b seg=%b exp=%b", $time, sel, e.sel, seg, e.seg);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    bit done = 0;
    for (int c = 0; c < 3 * FR; c++) begin
      @(negedge clk);
      checks++;
      if (q.size() == 0) begin failures++; $display("FAIL snapshot no expected entry"); end
      else begin
        e = q.pop_front();
        if (sel !== e.sel || seg !== e.seg) begin
          failures++;
          $display("FAIL snapshot t=%0t sel=%b exp=%b seg=%b exp=%b", $time, sel, e.sel, seg, e.seg);
        end
      end
      if (!done && pos % FR == 6) begin dig[3] = 4'd7; done = 1; end
    end
  endtask

  task automatic test_invalid();
    dig[2] = 4'hC;
    for (int c = 0; c < 2 * FR; c++) begin
      @(negedge clk);
      checks++;
      if (q.size() == 0) begin failures++; $display("FAIL invalid_code no expected entry"); end
      else begin
        e = q.pop_front();
        if (sel !== e.sel || seg !== e.seg) begin
          failures++;
          $display("FAIL invalid_code t=%0t sel=%b exp=%b seg=%b exp=%b", $time, sel, e.sel, seg, e.seg);
        end
      end
    end
    dig[2] = 4'd2;
  endtask

  task automatic test_blink();
    bit started = 0;
    int blanks = 0;
    for (int c = 0; c < 7 * FR; c++) begin
      @(negedge clk);
      checks++;
      if (q.size() == 0) begin failures++; $display("FAIL blink no expected entry"); end
      else begin
        e = q.pop_front();
        if (sel !== e.sel || seg !== e.seg) begin
          failures++;
          $display("FAIL blink t=%0t sel=%b exp=%b seg=%b exp=%b", $time, sel, e.sel, seg, e.seg);
        end
        if (started && sel == 6'b111011 && seg == 7'b0000000) blanks++;
      end
      if (!started && pos % FR == 0) begin blink_en = 1'b1; blink_pos = 3'd2; started = 1; end
    end
    // Six full blink frames: frames 2,3 off -> 2 frames x 3 lit cycles of slot 2.
    checks++;
    if (blanks < 6) begin failures++; $display("FAIL blink_count got=%0d exp>=6", blanks); end
  endtask

  task automatic test_blink_drop();
    int st = 0, n = 0;
    for (int c = 0; c < 10 * FR; c++) begin
      @(negedge clk);
      checks++;
      if (q.size() == 0) begin failures++; $display("FAIL blink_drop no expected entry"); end
      else begin
        e = q.pop_front();
        if (sel !== e.sel || seg !== e.seg) begin
          failures++;
          $display("FAIL blink_drop t=%0t sel=%b exp=%b seg=%b exp=%b", $time, sel, e.sel, seg, e.seg);
        end
      end
      if (st == 0 && ((wraps / BF) % 2) == 1 && pos % FR == 6) begin blink_en = 1'b0; st = 1; end
      else if (st == 1 && ++n == FR) begin blink_en = 1'b1; blink_pos = 3'd7; st = 2; end
    end
    blink_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    while (pos % SD != 2 || pos < SD) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (sel !== 6'b111111) begin failures++; $display("FAIL async_reset_sel got=%b exp=111111", sel); end
    checks++;
    if (seg !== 7'b0000000) begin failures++; $display("FAIL async_reset_seg got=%b exp=0000000", seg); end
    for (int i = 0; i < 6; i++) dig[i] = 4'(9 - i);
    repeat (2) @(negedge clk);
    q.delete();
    rst_n = 1'b1;
    for (int c = 0; c < 2 * FR; c++) begin
      @(negedge clk);
      checks++;
      if (q.size() == 0) begin failures++; $display("FAIL restart no expected entry"); end
      else begin
        e = q.pop_front();
        if (sel !== e.sel || seg !== e.seg) begin
          failures++;
          $display("FAIL restart t=%0t sel=%b exp=%b seg=%b exp=%b", $time, sel, e.sel, seg, e.seg);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_snapshot();
    test_invalid();
    test_blink();
    test_blink_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
